// File: rtl/mul32_seq.sv
// mul32_seq: iterative 32x32 unsigned shift-and-add multiplier built around one fa32 ripple adder.
module fa32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[32];
endmodule

module mul32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [31:0] mcand, hi, lo, add_b, sum, hi_n, lo_n;
  logic [4:0]  cnt;
  logic        cout, accept;
  assign add_b  = lo[0] ? mcand : 32'h0;
  assign accept = (state != RUN) && start;
  fa32 u_add (.a(hi), .b(add_b), .cin(1'b0), .sum(sum), .cout(cout));
  // cout becomes the new MSB of hi, so the 33-bit partial sum never overflows
  assign hi_n = {cout, sum[31:1]};
  assign lo_n = {sum[0], lo[31:1]};
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    if (accept)
      state_n = RUN;
    else if (state == RUN)
      state_n = cnt == 5'd31 ? DONE : RUN;
    else
      state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand <= a;
      lo    <= b;
      hi    <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) product <= {hi_n, lo_n};
    end
  end
endmodule
